// File: rtl/spi_slave_if.sv
// Local-side and pin-side signals of the SPI mode-0 responder, bundled for
// the DUT and its bench.
interface spi_slave_if;
  logic [7:0] tx_data;
  logic       tx_load;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       busy;
  logic       sclk;
  logic       mosi;
  logic       cs_n;
  logic       miso;

  modport slave (
    input  tx_data, tx_load, sclk, mosi, cs_n,
    output tx_ready, rx_data, rx_valid, busy, miso
  );

  modport master (
    output tx_data, tx_load, sclk, mosi, cs_n,
    input  tx_ready, rx_data, rx_valid, busy, miso
  );
endinterface

// File: rtl/spi_slave.sv
// SPI mode-0 responder: oversamples sclk/cs_n/mosi in clk_i, shifts 8-bit
// words MSB-first both ways, single-entry transmit buffer with bypass.
//
// state  | meaning
// IDLE   | synchronized cs_n high, sclk edges ignored, miso held 0
// ACTIVE | synchronized cs_n low, shifting on sclk edges
module spi_slave #(
  parameter int SYNC_STAGES = 2
) (
  input logic        clk_i,
  input logic        rst_ni,
  spi_slave_if.slave bus
);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q;
  logic                   sclk_hist_q, cs_hist_q;
  logic [2:0]             bit_cnt_q, bit_cnt_d;
  logic [7:0]             tx_shift_q, tx_shift_d;
  logic [7:0]             rx_shift_q, rx_shift_d;
  logic [7:0]             buf_q, buf_d;
  logic                   tx_ready_q, tx_ready_d;
  logic [7:0]             rx_data_q, rx_data_d;
  logic                   rx_valid_q, rx_valid_d;
  logic                   miso_q, miso_d;

  logic       sclk_s, cs_s, mosi_s;
  logic       sclk_rise, sclk_fall, cs_fall, cs_rise;
  logic       consume;
  logic [7:0] load_val;

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_hist_q;
  assign sclk_fall = ~sclk_s & sclk_hist_q;
  assign cs_fall   = ~cs_s & cs_hist_q;
  assign cs_rise   = cs_s & ~cs_hist_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      sclk_sync_q <= '0;
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
      sclk_hist_q <= 1'b0;
      cs_hist_q   <= 1'b1;
      bit_cnt_q   <= 3'd0;
      tx_shift_q  <= 8'h00;
      rx_shift_q  <= 8'h00;
      buf_q       <= 8'h00;
      tx_ready_q  <= 1'b1;
      rx_data_q   <= 8'h00;
      rx_valid_q  <= 1'b0;
      miso_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], bus.sclk};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], bus.cs_n};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], bus.mosi};
      sclk_hist_q <= sclk_s;
      cs_hist_q   <= cs_s;
      bit_cnt_q   <= bit_cnt_d;
      tx_shift_q  <= tx_shift_d;
      rx_shift_q  <= rx_shift_d;
      buf_q       <= buf_d;
      tx_ready_q  <= tx_ready_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      miso_q      <= miso_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    tx_shift_d = tx_shift_q;
    rx_shift_d = rx_shift_q;
    buf_d      = buf_q;
    tx_ready_d = tx_ready_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    miso_d     = miso_q;
    consume    = 1'b0;
    load_val   = 8'h00;

    case (state_q)
      IDLE: begin
        if (cs_fall) begin
          state_d   = ACTIVE;
          bit_cnt_d = 3'd0;
          consume   = 1'b1;
        end
      end
      ACTIVE: begin
        if (cs_rise) begin
          state_d   = IDLE;
          bit_cnt_d = 3'd0;
          miso_d    = 1'b0;
        end else if (sclk_rise) begin
          rx_shift_d = {rx_shift_q[6:0], mosi_s};
          bit_cnt_d  = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            rx_data_d  = {rx_shift_q[6:0], mosi_s};
            rx_valid_d = 1'b1;
          end
        end else if (sclk_fall) begin
          if (bit_cnt_q != 3'd0) begin
            tx_shift_d = {tx_shift_q[6:0], 1'b0};
            miso_d     = tx_shift_q[6];
          end else begin
            consume = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A consume takes the buffered byte if present, else a same-cycle load
    // bypasses straight into the shifter; an empty buffer sends zeros.
    if (consume) begin
      if (!tx_ready_q) begin
        load_val = buf_q;
        if (bus.tx_load) begin
          buf_d = bus.tx_data;
        end else begin
          tx_ready_d = 1'b1;
        end
      end else if (bus.tx_load) begin
        load_val = bus.tx_data;
      end
      tx_shift_d = load_val;
      miso_d     = load_val[7];
    end else if (bus.tx_load) begin
      buf_d      = bus.tx_data;
      tx_ready_d = 1'b0;
    end
  end

  assign bus.tx_ready = tx_ready_q;
  assign bus.rx_data  = rx_data_q;
  assign bus.rx_valid = rx_valid_q;
  assign bus.busy     = (state_q == ACTIVE);
  assign bus.miso     = miso_q;

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: drives the pins as an SPI master and checks
// received bytes, miso content, rx_valid pulses and buffer flags.
module tb_spi_slave;

  logic clk = 1'b0;
  logic rst_n;
  spi_slave_if bus ();

  spi_slave #(.SYNC_STAGES(2)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int         n_cmp = 0;
  int         n_err = 0;
  int         rx_cnt = 0;
  logic [7:0] rx_log[$];

  always @(negedge clk) begin
    if (bus.rx_valid === 1'b1) begin
      rx_cnt++;
      rx_log.push_back(bus.rx_data);
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load_tx(input logic [7:0] d);
    @(negedge clk);
    bus.tx_data = d;
    bus.tx_load = 1'b1;
    @(negedge clk);
    bus.tx_load = 1'b0;
  endtask

  // collide=1 asserts tx_load in the cycle the cs_n fall is being acted on
  task automatic spi_begin(input logic collide, input logic [7:0] d);
    @(negedge clk);
    bus.cs_n = 1'b0;
    wait_clk(2);
    if (collide) begin
      bus.tx_data = d;
      bus.tx_load = 1'b1;
    end
    @(negedge clk);
    bus.tx_load = 1'b0;
    check_eq("begin_busy", bus.busy, 1);
    check_eq("begin_tx_ready", bus.tx_ready, 1);
  endtask

  task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.mosi = tx[7-i];
      wait_clk(4);
      rx = {rx[6:0], bus.miso};
      bus.sclk = 1'b1;
      wait_clk(4);
      bus.sclk = 1'b0;
    end
  endtask

  task automatic spi_end();
    wait_clk(4);
    bus.cs_n = 1'b1;
    wait_clk(6);
    check_eq("end_busy", bus.busy, 0);
    check_eq("end_miso", bus.miso, 0);
  endtask

  initial begin
    logic [7:0] mrx;
    int         c0;

    rst_n       = 1'b0;
    bus.tx_data = 8'h00;
    bus.tx_load = 1'b0;
    bus.sclk    = 1'b0;
    bus.mosi    = 1'b0;
    bus.cs_n    = 1'b1;
    wait_clk(3);
    rst_n = 1'b1;
    wait_clk(2);

    check_eq("rst_miso", bus.miso, 0);
    check_eq("rst_rx_data", bus.rx_data, 8'h00);
    check_eq("rst_rx_valid", bus.rx_valid, 0);
    check_eq("rst_busy", bus.busy, 0);
    check_eq("rst_tx_ready", bus.tx_ready, 1);

    // single byte
    load_tx(8'hA5);
    check_eq("single_tx_ready_full", bus.tx_ready, 0);
    c0 = rx_cnt;
    spi_begin(1'b0, 8'h00);
    check_eq("single_miso_msb", bus.miso, 1);
    spi_bits(8'h3C, 8, mrx);
    spi_end();
    check_eq("single_master_rx", mrx, 8'hA5);
    check_eq("single_rx_data", bus.rx_data, 8'h3C);
    check_eq("single_rx_pulses", rx_cnt - c0, 1);
    check_eq("single_rx_log", rx_log[c0], 8'h3C);
    check_eq("single_tx_ready", bus.tx_ready, 1);

    // back-to-back with refill after first consume
    load_tx(8'h11);
    c0 = rx_cnt;
    spi_begin(1'b0, 8'h00);
    load_tx(8'h22);
    check_eq("b2b_refill_full", bus.tx_ready, 0);
    spi_bits(8'hF0, 8, mrx);
    check_eq("b2b_master_rx0", mrx, 8'h11);
    spi_bits(8'h0F, 8, mrx);
    check_eq("b2b_master_rx1", mrx, 8'h22);
    spi_end();
    check_eq("b2b_rx_pulses", rx_cnt - c0, 2);
    check_eq("b2b_rx0", rx_log[c0], 8'hF0);
    check_eq("b2b_rx1", rx_log[c0+1], 8'h0F);
    check_eq("b2b_tx_ready", bus.tx_ready, 1);

    // underrun
    c0 = rx_cnt;
    spi_begin(1'b0, 8'h00);
    spi_bits(8'hC3, 8, mrx);
    spi_end();
    check_eq("under_master_rx", mrx, 8'h00);
    check_eq("under_rx_pulses", rx_cnt - c0, 1);
    check_eq("under_rx_data", bus.rx_data, 8'hC3);

    // abort after 5 bits, then a clean transaction
    c0 = rx_cnt;
    spi_begin(1'b0, 8'h00);
    spi_bits(8'hFF, 5, mrx);
    spi_end();
    check_eq("abort_rx_pulses", rx_cnt - c0, 0);
    check_eq("abort_rx_data", bus.rx_data, 8'hC3);
    load_tx(8'h81);
    spi_begin(1'b0, 8'h00);
    spi_bits(8'h7E, 8, mrx);
    spi_end();
    check_eq("post_abort_master_rx", mrx, 8'h81);
    check_eq("post_abort_rx_pulses", rx_cnt - c0, 1);
    check_eq("post_abort_rx_data", bus.rx_data, 8'h7E);

    // load collides with cs_fall consume while buffer is empty
    c0 = rx_cnt;
    spi_begin(1'b1, 8'h5A);
    check_eq("collide_miso_msb", bus.miso, 0);
    spi_bits(8'hA0, 8, mrx);
    spi_end();
    check_eq("collide_master_rx", mrx, 8'h5A);
    check_eq("collide_rx_data", bus.rx_data, 8'hA0);
    check_eq("collide_tx_ready", bus.tx_ready, 1);

    // reset in the middle of a byte
    load_tx(8'h33);
    c0 = rx_cnt;
    spi_begin(1'b0, 8'h00);
    spi_bits(8'hFF, 3, mrx);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_miso", bus.miso, 0);
    check_eq("mid_rst_rx_data", bus.rx_data, 8'h00);
    check_eq("mid_rst_rx_valid", bus.rx_valid, 0);
    check_eq("mid_rst_busy", bus.busy, 0);
    check_eq("mid_rst_tx_ready", bus.tx_ready, 1);
    bus.cs_n = 1'b1;
    bus.sclk = 1'b0;
    bus.mosi = 1'b0;
    wait_clk(2);
    rst_n = 1'b1;
    wait_clk(4);
    check_eq("mid_rst_no_pulse", rx_cnt - c0, 0);
    load_tx(8'h96);
    spi_begin(1'b0, 8'h00);
    spi_bits(8'h69, 8, mrx);
    spi_end();
    check_eq("post_rst_master_rx", mrx, 8'h96);
    check_eq("post_rst_rx_data", bus.rx_data, 8'h69);
    check_eq("post_rst_rx_pulses", rx_cnt - c0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/spi_slave.md
# spi_slave

SPI mode-0 (CPOL=0, CPHA=0) responder for the opposite end of the link driven by the team's SPI master. It oversamples the external sclk/cs_n/mosi in the local clk domain and shifts 8-bit words MSB-first in both directions. A single-entry transmit buffer is loaded by local logic, and each received byte is presented with a one-cycle valid strobe. The block is the DUT-side responder and the reference model for master-loopback benches.

## Interface
- SYNC_STAGES, 2: synchronizer depth for sclk, cs_n and mosi (≥2).
- clk  input  1  system clock; all logic is on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- tx_data  input  8  next byte to transmit.
- tx_load  input  1  writes tx_data into the transmit buffer this cycle.
- tx_ready  output  1  transmit buffer empty (1 = free).
- rx_data  output  8  last fully received byte; held until the next byte completes.
- rx_valid  output  1  one-cycle pulse when rx_data updates.
- busy  output  1  synchronized cs_n is low (transaction active).
- sclk  input  1  SPI clock from the master (asynchronous to clk).
- mosi  input  1  master-out data.
- cs_n  input  1  active-low chip select.
- miso  output  1  slave-out data; driven 0 while deselected (no tri-state).

## Operation
- Synchronizers: sclk, cs_n and mosi each pass through SYNC_STAGES flops, followed by one history flop. Edge detects are taken from the last synchronizer stage against the history flop: sclk_rise, sclk_fall, cs_fall, cs_rise.
- States:
  - IDLE (cs high).
  - ACTIVE (cs low).
- IDLE→ACTIVE on cs_fall:
  - bit_cnt=0.
  - Load tx_shift from the buffer (0x00 if the buffer is empty).
  - miso=tx_shift MSB.
  - Buffer marked consumed (tx_ready=1).
- ACTIVE, sclk_rise:
  - rx_shift ← {rx_shift[6:0], mosi_sync}.
  - bit_cnt increments, wrapping 7→0.
  - On the wrap, rx_data ← the completed byte and rx_valid pulses.
- ACTIVE, sclk_fall with bit_cnt≠0: tx_shift shifts left and miso = the new MSB.
- ACTIVE, sclk_fall with bit_cnt=0 (a byte just completed, cs still low): reload tx_shift from the buffer (or 0x00 if empty). This gives back-to-back bytes without a gap.
- ACTIVE→IDLE on cs_rise:
  - Any partial byte is discarded, with no rx_valid.
  - bit_cnt=0 and miso=0.
  - The buffer contents are kept.
- Transmit buffer:
  - tx_load with tx_ready=1 fills the buffer; tx_ready falls next cycle.
  - tx_load with tx_ready=0 overwrites the buffer (last write wins).
  - tx_load in the same cycle as a consume (cs_fall or reload) with an empty buffer: tx_data is bypassed straight into tx_shift and the buffer stays empty.
  - tx_load in the same cycle as a consume with a full buffer: the old contents go to tx_shift, tx_data becomes the new buffer entry, and tx_ready stays 0.
- sclk edges while IDLE are ignored. cs_fall and cs_rise detected together are impossible by construction (single sync path).
- Reset values:
  - miso=0, rx_data=0x00, rx_valid=0, busy=0, tx_ready=1.
  - tx_shift, rx_shift, bit_cnt and buffer are 0.
  - cs_n synchronizer flops reset to 1; sclk and mosi synchronizer flops reset to 0.
  - Reset mid-transaction aborts immediately with no rx_valid.

## Timing
- Edge-detect latency is SYNC_STAGES+1 clk edges after the pin change (3 at default).
- miso updates on the cycle its edge is detected: ≤3 clk after cs_n fall or sclk fall.
- rx_valid pulses on the clk edge after the 8th sclk_rise is detected (≤4 clk after the pin edge). rx_data is valid in the same cycle as the pulse.
- busy rises 3 clk after cs_n falls and drops 3 clk after it rises.
- Master constraints:
  - sclk high and low each ≥4 clk.
  - cs_n low → first sclk rise ≥4 clk.
  - Last sclk fall → cs_n rise ≥4 clk.
  - mosi stable ≥4 clk around each sclk rise.
- tx_ready rises the cycle after a consume and falls the cycle after tx_load.

## Test plan
- Single byte:
  - Stimulus: tx_load 0xA5; master sends 0x3C at half-period 4 clk.
  - Required: master receives 0xA5; rx_data=0x3C with one rx_valid pulse; tx_ready returns to 1.
- Back-to-back:
  - Stimulus: buffer 0x11, refilled with 0x22 after the first consume; cs_n held low for 16 sclk; master sends 0xF0, 0x0F.
  - Required: miso carries 0x11 then 0x22; two rx_valid pulses carrying 0xF0, 0x0F.
- Underrun: no tx_load before cs_fall → miso carries 0x00 and rx still works.
- Abort: cs_n rises after 5 sclk → no rx_valid, rx_data unchanged; the next full transaction receives correctly.
- Load collision: tx_load 0x5A in the exact cycle cs_fall is detected with an empty buffer → 0x5A is transmitted and tx_ready stays 1.
- Reset mid-byte: rst_n low after 3 bits → all outputs at reset values; a subsequent transaction is clean.
